// File: rtl/branch_ctrl_if.sv
// Fetch-unit side bus of the branch controller: fetched word and zero flag in,
// branch strobe, decode status and counters out.
interface branch_ctrl_if;
  logic [15:0] opcode_in;
  logic        flag_z;
  logic        BR;
  logic        instr_valid;
  logic [7:0]  loop_cnt;
  logic [15:0] taken_cnt;
  logic        halted;

  modport master (
    output opcode_in, flag_z,
    input  BR, instr_valid, loop_cnt, taken_cnt, halted
  );

  modport slave (
    input  opcode_in, flag_z,
    output BR, instr_valid, loop_cnt, taken_cnt, halted
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: decodes JMP/JZ/LOOP/DJNZ/HALT from the fetched word and
// strobes BR one cycle after a taken branch, while the target word is on the bus.
//
// state  | meaning
// EXEC   | opcode_in is an instruction and is decoded
// TARGET | opcode_in is a branch target word; BR = take, never decoded
// HALT   | stopped until reset; all inputs ignored
module branch_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    EXEC   = 2'd0,
    TARGET = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_LOOP = 4'hD;
  localparam logic [3:0] OP_DJNZ = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hB;

  state_t     state;
  logic       take;
  logic [3:0] op_class;
  logic       djnz_take;

  assign op_class  = bus.opcode_in[15:12];
  // Taken only while the decremented count is still non-zero; a zero count stays put.
  assign djnz_take = (bus.loop_cnt > 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= EXEC;
      take            <= 1'b0;
      bus.BR          <= 1'b0;
      bus.instr_valid <= 1'b1;
      bus.loop_cnt    <= 8'h00;
      bus.taken_cnt   <= 16'h0000;
      bus.halted      <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          case (op_class)
            OP_JMP: begin
              state           <= TARGET;
              take            <= 1'b1;
              bus.BR          <= 1'b1;
              bus.instr_valid <= 1'b0;
            end
            OP_JZ: begin
              state           <= TARGET;
              take            <= bus.flag_z;
              bus.BR          <= bus.flag_z;
              bus.instr_valid <= 1'b0;
            end
            OP_DJNZ: begin
              state           <= TARGET;
              take            <= djnz_take;
              bus.BR          <= djnz_take;
              bus.instr_valid <= 1'b0;
              if (bus.loop_cnt != 8'h00)
                bus.loop_cnt <= bus.loop_cnt - 8'd1;
            end
            OP_LOOP: begin
              bus.loop_cnt <= bus.opcode_in[7:0];
            end
            OP_HALT: begin
              state           <= HALT;
              bus.halted      <= 1'b1;
              bus.BR          <= 1'b0;
              bus.instr_valid <= 1'b0;
            end
            default: begin
            end
          endcase
        end
        TARGET: begin
          state           <= EXEC;
          take            <= 1'b0;
          bus.BR          <= 1'b0;
          bus.instr_valid <= 1'b1;
          if (take && bus.taken_cnt != 16'hFFFF)
            bus.taken_cnt <= bus.taken_cnt + 16'd1;
        end
        HALT: begin
          bus.BR          <= 1'b0;
          bus.instr_valid <= 1'b0;
          bus.halted      <= 1'b1;
        end
        default: begin
          state           <= EXEC;
          take            <= 1'b0;
          bus.BR          <= 1'b0;
          bus.instr_valid <= 1'b1;
          bus.halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
